ram_loader: RTL and testbench

//  Bus initiator for the 256x16 program/data RAM port (address, write, data_in, data_out).

---
 rtl/ram_loader.sv | 171 +++++++++++++++++
 tb/tb_ram_loader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader.sv
// Byte-stream loader/dumper for a 256x16 RAM port: LOAD packs big-endian byte pairs into
// words written from address 0 upward, DUMP reads words back out as byte pairs.
module ram_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_load,
    input  logic              start_dump,
    input  logic [ADDR_W-1:0] len,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LD_HI = 3'd1,
        S_LD_LO = 3'd2,
        S_LD_WR = 3'd3,
        S_DP_RD = 3'd4,
        S_DP_HI = 3'd5,
        S_DP_LO = 3'd6,
        S_FIN   = 3'd7
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_hold;

    logic [ADDR_W-1:0] w_last_cnt;
    logic              w_last;
    logic              w_in_ready;
    logic              w_out_valid;
    logic [7:0]        w_out_data;

    // len==0 wraps to 2**ADDR_W words, so the final count is len-1 modulo 2**ADDR_W
    assign w_last_cnt = r_len - {{(ADDR_W-1){1'b0}}, 1'b1};
    assign w_last     = (r_cnt == w_last_cnt);

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_out_data   = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (start_load) begin
                    w_next_state = S_LD_HI;
                end else if (start_dump) begin
                    w_next_state = S_DP_RD;
                end
            end
            S_LD_HI: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = S_LD_LO;
                end
            end
            S_LD_LO: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = S_LD_WR;
                end
            end
            S_LD_WR: begin
                w_next_state = w_last ? S_FIN : S_LD_HI;
            end
            S_DP_RD: begin
                w_next_state = S_DP_HI;
            end
            S_DP_HI: begin
                w_out_valid = 1'b1;
                w_out_data  = r_hold[15:8];
                if (out_ready) begin
                    w_next_state = S_DP_LO;
                end
            end
            S_DP_LO: begin
                w_out_valid = 1'b1;
                w_out_data  = r_hold[7:0];
                if (out_ready) begin
                    w_next_state = w_last ? S_FIN : S_DP_RD;
                end
            end
            S_FIN: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (start_load || start_dump) begin
                        r_len  <= len;
                        r_addr <= '0;
                        r_cnt  <= '0;
                    end
                end
                S_LD_HI: begin
                    if (in_valid) begin
                        r_wdata[15:8] <= in_data;
                    end
                end
                S_LD_LO: begin
                    if (in_valid) begin
                        r_wdata[7:0] <= in_data;
                    end
                end
                S_LD_WR: begin
                    // address holds at the last word so it reads 255 after a full-range run
                    if (!w_last) begin
                        r_addr <= r_addr + 1'b1;
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end
                S_DP_RD: begin
                    r_hold <= mem_rdata;
                end
                S_DP_LO: begin
                    if (out_ready && !w_last) begin
                        r_addr <= r_addr + 1'b1;
                        r_cnt  <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Strobe and status come straight from the state register, so reset clears them at once
    assign mem_write = (r_state == S_LD_WR);
    assign busy      = (r_state != S_IDLE);
    assign cpu_hold  = busy;
    assign done      = (r_state == S_FIN);
    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = w_out_data;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: behavioural RAM on the port, expected words computed from the byte
// stream, randomized gaps/backpressure, directed steps in one initial block.
module tb_ram_loader;

    logic        clk;
    logic        rst_n;
    logic        start_load;
    logic        start_dump;
    logic [7:0]  len;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  mem_addr;
    logic        mem_write;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        cpu_hold;
    logic        done;

    ram_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_load (start_load),
        .start_dump (start_dump),
        .len        (len),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .mem_addr   (mem_addr),
        .mem_write  (mem_write),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .cpu_hold   (cpu_hold),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM attached to the port
    logic [15:0] ram [256];
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) begin
        if (mem_write) ram[mem_addr] <= mem_wdata;
    end

    int          n_cmp;
    int          n_fail;
    logic [7:0]  src [512];
    logic [15:0] exp_mem [256];
    logic [7:0]  wr_addr [512];
    logic [15:0] wr_data [512];
    int          nwr;
    int          done_cyc;
    logic [15:0] snap [256];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // LOAD n words (1..256) from src[], optional input gaps and stray start pulses
    task automatic do_load(input int n, input int max_gap, input bit pulse, input bit both,
                           output int dcyc);
        int  idx;
        int  gap;
        int  cyc;
        int  busy_err;
        bit  hs;
        bit  seen;
        idx = 0; gap = 0; busy_err = 0; seen = 0; nwr = 0; dcyc = -1;
        start_load = 1'b1;
        start_dump = both;
        len = 8'(n);
        step();
        start_load = 1'b0;
        start_dump = 1'b0;
        cyc = 1;
        if (both) check("both_start_load_wins", 32'(in_ready), 32'd1);
        for (int c = 0; c < 20000; c++) begin
            if (done) begin
                seen = 1'b1;
                dcyc = cyc;
                break;
            end
            if (!busy || !cpu_hold) busy_err++;
            if (mem_write && nwr < 512) begin
                wr_addr[nwr] = mem_addr;
                wr_data[nwr] = mem_wdata;
                nwr++;
            end
            if (gap > 0) begin
                in_valid = 1'b0;
                gap--;
            end else begin
                in_valid = 1'b1;
                in_data  = src[idx < 512 ? idx : 511];
            end
            if (pulse) begin
                start_load = 1'($urandom % 2);
                start_dump = 1'($urandom % 2);
                len        = 8'($urandom);
            end
            hs = in_valid && in_ready;
            step();
            cyc++;
            if (hs) begin
                idx++;
                gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            end
        end
        in_valid = 1'b0;
        start_load = 1'b0;
        start_dump = 1'b0;
        check("load_done_seen", 32'(seen), 32'd1);
        check("load_bytes_taken", 32'(idx), 32'(2 * n));
        check("load_write_count", 32'(nwr), 32'(n));
        check("load_busy_held", 32'(busy_err), 32'd0);
        for (int k = 0; k < n; k++) exp_mem[k] = {src[2*k], src[2*k+1]};
        for (int k = 0; k < n && k < nwr; k++) begin
            check("load_wr_addr", 32'(wr_addr[k]), 32'(k));
            check("load_wr_data", 32'(wr_data[k]), 32'(exp_mem[k]));
        end
        step();
        check("load_done_one_cycle", 32'(done), 32'd0);
        check("load_idle_busy", 32'(busy), 32'd0);
        for (int k = 0; k < n; k++) check("load_ram", 32'(ram[k]), 32'(exp_mem[k]));
    endtask

    // DUMP n words with random backpressure; expected bytes from the word model
    task automatic do_dump(input int n);
        int         idx;
        int         wr_err;
        int         busy_err;
        int         stab_err;
        bit         prev_stall;
        bit         seen;
        logic [7:0] prev_data;
        logic [7:0] want;
        idx = 0; wr_err = 0; busy_err = 0; stab_err = 0; prev_stall = 0; seen = 0;
        prev_data = 8'h00;
        start_dump = 1'b1;
        len = 8'(n);
        step();
        start_dump = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (mem_write) wr_err++;
            if (!busy || !cpu_hold) busy_err++;
            if (prev_stall && (!out_valid || out_data !== prev_data)) stab_err++;
            out_ready = 1'($urandom % 2);
            if (out_valid && out_ready) begin
                want = (idx % 2 == 0) ? exp_mem[(idx / 2) % 256][15:8]
                                      : exp_mem[(idx / 2) % 256][7:0];
                check("dump_byte", 32'(out_data), 32'(want));
                idx++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            step();
        end
        out_ready = 1'b0;
        check("dump_done_seen", 32'(seen), 32'd1);
        check("dump_byte_count", 32'(idx), 32'(2 * n));
        check("dump_no_write", 32'(wr_err), 32'd0);
        check("dump_busy_held", 32'(busy_err), 32'd0);
        check("dump_stall_stable", 32'(stab_err), 32'd0);
        step();
        check("dump_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_cnt;
        bit hs;
        int n;
        n_cmp = 0; n_fail = 0;
        rst_n = 1'b0; start_load = 1'b0; start_dump = 1'b0; len = 8'h00;
        in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        step();

        // Step 1: LOAD len=2, 12 34 AB CD, valid always high
        src[0] = 8'h12; src[1] = 8'h34; src[2] = 8'hAB; src[3] = 8'hCD;
        do_load(2, 0, 1'b0, 1'b0, done_cyc);
        check("t1_done_latency", 32'(done_cyc), 32'd7);
        check("t1_word0", 32'(ram[0]), 32'h1234);
        check("t1_word1", 32'(ram[1]), 32'hABCD);
        $display("step1 load len=2 writes=%0d done_cyc=%0d", nwr, done_cyc);

        // Step 2: DUMP len=2 with random backpressure
        do_dump(2);
        $display("step2 dump len=2");

        // Step 3: LOAD len=0 -> 256 words of incrementing bytes, then dump all
        for (int i = 0; i < 512; i++) src[i] = 8'(i);
        do_load(256, 0, 1'b0, 1'b0, done_cyc);
        check("t3_addr_at_end", 32'(mem_addr), 32'd255);
        check("t3_last_write_addr", 32'(wr_addr[255]), 32'd255);
        $display("step3 load len=0 writes=%0d", nwr);
        do_dump(256);
        $display("step3 dump len=0");

        // Step 4: simultaneous starts, stray pulses while busy
        for (int i = 0; i < 10; i++) src[i] = 8'($urandom);
        do_load(5, 2, 1'b1, 1'b1, done_cyc);
        do_dump(5);
        $display("step4 both-start load len=5 writes=%0d", nwr);

        // Step 5: reset after the high-byte handshake of word 1
        for (int i = 0; i < 6; i++) src[i] = 8'($urandom);
        start_load = 1'b1; len = 8'd3;
        step();
        start_load = 1'b0;
        hs_cnt = 0; nwr = 0;
        for (int c = 0; c < 50 && hs_cnt < 3; c++) begin
            if (mem_write && nwr < 512) begin
                wr_addr[nwr] = mem_addr;
                nwr++;
            end
            in_valid = 1'b1;
            in_data  = src[hs_cnt];
            hs = in_ready;
            step();
            if (hs) hs_cnt++;
        end
        in_valid = 1'b0;
        check("t5_hs_reached", 32'(hs_cnt), 32'd3);
        rst_n = 1'b0;
        #1;
        check("t5_rst_mem_write", 32'(mem_write), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("t5_rst_in_ready", 32'(in_ready), 32'd0);
        check("t5_rst_mem_addr", 32'(mem_addr), 32'd0);
        check("t5_rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("t5_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_one_write", 32'(nwr), 32'd1);
        check("t5_write_addr0", 32'(wr_addr[0]), 32'd0);
        exp_mem[0] = {src[0], src[1]};
        check("t5_word0", 32'(ram[0]), 32'(exp_mem[0]));
        check("t5_word1_untouched", 32'(ram[1]), 32'(exp_mem[1]));
        step();
        for (int i = 0; i < 2; i++) src[i] = 8'($urandom);
        do_load(1, 0, 1'b0, 1'b0, done_cyc);
        $display("step5 reset abort, reload writes=%0d addr=%0d", nwr, wr_addr[0]);

        // Step 6: same data with and without input gaps
        n = 37;
        for (int i = 0; i < 2 * n; i++) src[i] = 8'($urandom);
        do_load(n, 0, 1'b0, 1'b0, done_cyc);
        for (int k = 0; k < n; k++) snap[k] = ram[k];
        do_load(n, 5, 1'b0, 1'b0, done_cyc);
        check("t6_write_count", 32'(nwr), 32'(n));
        for (int k = 0; k < n; k++) check("t6_same_ram", 32'(ram[k]), 32'(snap[k]));
        do_dump(n);
        $display("step6 gapped load len=%0d writes=%0d", n, nwr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
